// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer.
// Owns the architectural fetch PC and issues one instruction fetch at a time
// over a valid/ready request/response pair. Redirects from execute steer the
// PC; fetches that were already in flight are discarded as wrong-path.
// Fetched instructions reach decode through a one-entry output register.
module fetch_pc_ctrl #(
    parameter int unsigned         WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = {WordSize{1'b0}},
    parameter int unsigned         InstBytes   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [WordSize-1:0] redirect_addr,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    output logic                imem_resp_ready,
    input  logic [WordSize-1:0] imem_resp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [WordSize-1:0] if_pc,
    output logic [WordSize-1:0] if_inst,
    output logic [WordSize-1:0] pc
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [WordSize-1:0] PC_INC     = WordSize'(InstBytes);
    localparam logic [WordSize-1:0] ONE        = {{(WordSize-1){1'b0}}, 1'b1};
    localparam logic [WordSize-1:0] ALIGN_MASK = ~(PC_INC - ONE);

    // Clears the sub-instruction offset bits of a redirect target.
    function automatic logic [WordSize-1:0] align_pc(input logic [WordSize-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    state_t              state_r;
    logic [WordSize-1:0] pc_r;
    logic [WordSize-1:0] fetch_pc_r;
    logic                if_valid_r;
    logic [WordSize-1:0] if_pc_r;
    logic [WordSize-1:0] if_inst_r;

    logic                req_valid_s;
    logic                resp_ready_s;
    logic                req_fire_s;
    logic                resp_fire_s;
    logic [WordSize-1:0] redirect_pc_s;

    // Handshake enables decoded from the current state.
    always_comb begin
        req_valid_s  = 1'b0;
        resp_ready_s = 1'b0;
        case (state_r)
            REQ: begin
                req_valid_s = 1'b1;
            end
            WAIT: begin
                resp_ready_s = !if_valid_r || if_ready;
            end
            DROP: begin
                resp_ready_s = 1'b1;
            end
            default: begin
                req_valid_s  = 1'b0;
                resp_ready_s = 1'b0;
            end
        endcase
    end

    assign req_fire_s    = req_valid_s && imem_req_ready;
    assign resp_fire_s   = imem_resp_valid && resp_ready_s;
    assign redirect_pc_s = align_pc(redirect_addr);

    // Sequencer FSM with PC and in-flight fetch address; redirect has priority
    // over every other PC update and turns any in-flight fetch into wrong-path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HOLD;
            pc_r       <= ResetVector;
            fetch_pc_r <= {WordSize{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc_s;
                    end
                    state_r <= stall ? HOLD : REQ;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc_r    <= redirect_pc_s;
                        state_r <= req_fire_s ? DROP : REQ;
                    end else if (req_fire_s) begin
                        fetch_pc_r <= pc_r;
                        pc_r       <= pc_r + PC_INC;
                        state_r    <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc_s;
                        if (resp_fire_s) begin
                            state_r <= stall ? HOLD : REQ;
                        end else begin
                            state_r <= DROP;
                        end
                    end else if (resp_fire_s) begin
                        state_r <= stall ? HOLD : REQ;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DROP: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc_s;
                    end
                    if (imem_resp_valid) begin
                        state_r <= stall ? HOLD : REQ;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= HOLD;
                end
            endcase
        end
    end

    // Decode output register: redirect flushes it, a right-path response loads
    // it, and a consume empties it unless a new load lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_r <= 1'b0;
            if_pc_r    <= {WordSize{1'b0}};
            if_inst_r  <= {WordSize{1'b0}};
        end else begin
            if (redirect_valid) begin
                if_valid_r <= 1'b0;
            end else if ((state_r == WAIT) && resp_fire_s) begin
                if_valid_r <= 1'b1;
                if_pc_r    <= fetch_pc_r;
                if_inst_r  <= imem_resp_data;
            end else if (if_valid_r && if_ready) begin
                if_valid_r <= 1'b0;
            end else begin
                if_valid_r <= if_valid_r;
            end
        end
    end

    assign imem_req_valid  = req_valid_s;
    assign imem_req_addr   = pc_r;
    assign imem_resp_ready = resp_ready_s;
    assign if_valid        = if_valid_r;
    assign if_pc           = if_pc_r;
    assign if_inst         = if_inst_r;
    assign pc              = pc_r;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed testbench for fetch_pc_ctrl (ResetVector = 0x100, InstBytes = 4).
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] pc;

    int errors = 0;
    int checks = 0;

    fetch_pc_ctrl #(
        .WordSize(32),
        .ResetVector(32'h0000_0100),
        .InstBytes(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
        .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_inst(if_inst), .pc(pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        if_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Entered in REQ; accepts the request, returns data one cycle later.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] npc, input logic [31:0] d);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
            errors++;
            $display("FAIL fetch_req: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, a);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || pc !== npc) begin
            errors++;
            $display("FAIL fetch_accept: req_valid=%b pc=%h, required 0 pc=%h", imem_req_valid, pc, npc);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = d;
        step();
        imem_resp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== a || if_inst !== d) begin
            errors++;
            $display("FAIL fetch_resp: if_valid=%b if_pc=%h if_inst=%h, required 1 %h %h", if_valid, if_pc, if_inst, a, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_resp_ready !== 1'b0 || if_valid !== 1'b0 ||
            pc !== 32'h100 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rv=%b rr=%b iv=%b pc=%h ifpc=%h inst=%h", imem_req_valid, imem_resp_ready, if_valid, pc, if_pc, if_inst);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: req_valid=%b, required 0", imem_req_valid);
        end
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h, required 1 00000100", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        if_ready = 1'b1;
        fetch_one(32'h100, 32'h104, 32'hA000_0001);
        fetch_one(32'h104, 32'h108, 32'hA000_0002);
        fetch_one(32'h108, 32'h10C, 32'hA000_0003);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
                errors++;
                $display("FAIL bp_req_hold: cyc=%0d valid=%b addr=%h, required 1 00000100", i, imem_req_valid, imem_req_addr);
            end
        end
        fetch_one(32'h100, 32'h104, 32'hB000_0000);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hB000_0001;
        #1;
        checks++;
        if (imem_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp_ready_low: resp_ready=%b, required 0", imem_resp_ready);
        end
        step();
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'hB000_0000 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_output_held: iv=%b ifpc=%h inst=%h rv=%b, required 1 00000100 b0000000 0", if_valid, if_pc, if_inst, imem_req_valid);
        end
        if_ready = 1'b1;
        #1;
        checks++;
        if (imem_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_resp_ready_high: resp_ready=%b, required 1", imem_resp_ready);
        end
        step();
        imem_resp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_inst !== 32'hB000_0001) begin
            errors++;
            $display("FAIL bp_back_to_back: iv=%b ifpc=%h inst=%h, required 1 00000104 b0000001", if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        if_ready = 1'b1;
        fetch_one(32'h100, 32'h104, 32'hC000_0000);
        if_ready = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || pc !== 32'h200 || imem_req_valid !== 1'b0 || imem_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rw_drop: iv=%b pc=%h rv=%b rr=%b, required 0 00000200 0 1", if_valid, pc, imem_req_valid, imem_resp_ready);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_0104;
        step();
        imem_resp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_discard: if_valid=%b, required 0", if_valid);
        end
        if_ready = 1'b1;
        fetch_one(32'h200, 32'h204, 32'hC000_0200);
    endtask

    task automatic test_redirect_handshake();
        do_reset();
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'h300;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_resp_ready !== 1'b1 || pc !== 32'h300) begin
            errors++;
            $display("FAIL rh_drop: rv=%b rr=%b pc=%h, required 0 1 00000300", imem_req_valid, imem_resp_ready, pc);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_0100;
        step();
        imem_resp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            errors++;
            $display("FAIL rh_after_drop: iv=%b rv=%b addr=%h, required 0 1 00000300", if_valid, imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'h302;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_0300;
        step();
        imem_resp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            errors++;
            $display("FAIL rh_unaligned: iv=%b rv=%b addr=%h, required 0 1 00000300", if_valid, imem_req_valid, imem_req_addr);
        end
        redirect_valid = 1'b1;
        redirect_addr = 32'h400;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin
            errors++;
            $display("FAIL rh_withdraw: rv=%b addr=%h, required 1 00000400", imem_req_valid, imem_req_addr);
        end
        fetch_one(32'h400, 32'h404, 32'hC000_0400);
    endtask

    task automatic test_stall();
        do_reset();
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        stall = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hE000_0100;
        step();
        imem_resp_valid = 1'b0;
        if_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h100) begin
            errors++;
            $display("FAIL st_hold: rv=%b iv=%b ifpc=%h, required 0 1 00000100", imem_req_valid, if_valid, if_pc);
        end
        step();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL st_hold2: req_valid=%b, required 0", imem_req_valid);
        end
        stall = 1'b0;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
            errors++;
            $display("FAIL st_release: rv=%b addr=%h, required 1 00000104", imem_req_valid, imem_req_addr);
        end
        stall = 1'b1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h108) begin
            errors++;
            $display("FAIL st_req_ignores_stall: rv=%b pc=%h, required 0 00000108", imem_req_valid, pc);
        end
        if_ready = 1'b1;
        #1;
        checks++;
        if (imem_resp_ready !== 1'b1 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL st_wait_pre_reset: rr=%b iv=%b, required 1 1", imem_resp_ready, if_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_resp_ready !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h100) begin
            errors++;
            $display("FAIL st_async_reset: rv=%b rr=%b iv=%b pc=%h, required 0 0 0 00000100", imem_req_valid, imem_resp_ready, if_valid, pc);
        end
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h0000_0000, 32'hF000_0001);
        fetch_one(32'h0000_0000, 32'h0000_0004, 32'hF000_0002);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_handshake();
        test_stall();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
